// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pkg
//  Purpose  : Default 640x480@60 raster constants and small timing helpers.
//  Revision : 1.0
// ============================================================================
package vga_timing_pkg;

    localparam int DEF_H_VISIBLE   = 640;
    localparam int DEF_H_FRONT     = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BACK      = 48;
    localparam int DEF_V_VISIBLE   = 480;
    localparam int DEF_V_FRONT     = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BACK      = 33;
    localparam bit DEF_SYNC_ACTIVE = 1'b0;
    localparam int DEF_PIPE_DELAY  = 2;

    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int COORD_W     = 10;
    localparam int FRAME_CNT_W = 16;
    localparam int MAX_TOTAL   = 1 << COORD_W;

    function automatic int span_total(input int a, input int b, input int c, input int d);
        return a + b + c + d;
    endfunction

    // True when pos lies in the half-open window [start, start+len)
    function automatic logic in_window(input int pos, input int start, input int len);
        return (pos >= start) && (pos < start + len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen_if
//  Purpose  : Raster coordinate, blank, sync and strobe bundle.
//  Revision : 1.0
// ============================================================================
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic [COORD_W-1:0]     DrawX;
    logic [COORD_W-1:0]     DrawY;
    logic                   blank;
    logic                   hs;
    logic                   vs;
    logic                   line_start;
    logic                   frame_start;
    logic [FRAME_CNT_W-1:0] frame_count;

    modport master (
        output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );

    modport slave (
        input DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );

endinterface
`default_nettype wire

// File: rtl/sync_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : sync_delay_line
//  Purpose  : Fixed-depth shift register, synchronously reset to RESET_VAL.
//  Revision : 1.0
// ============================================================================
module sync_delay_line #(
    parameter int               DEPTH     = 2,
    parameter int               WIDTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RESET_VAL;
                    end
                end else begin
                    r_stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign dout = r_stage[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : VGA raster counters, blank, delayed hs/vs, strobes, frame count.
//  Revision : 1.0
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE   = DEF_H_VISIBLE,
    parameter int H_FRONT     = DEF_H_FRONT,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int V_VISIBLE   = DEF_V_VISIBLE,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BACK      = DEF_V_BACK,
    parameter bit SYNC_ACTIVE = DEF_SYNC_ACTIVE,
    parameter int PIPE_DELAY  = DEF_PIPE_DELAY
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    vga_timing_gen_if.master vga
);

    localparam int C_H_TOTAL = span_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int C_V_TOTAL = span_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam logic [COORD_W-1:0] C_H_LAST    = COORD_W'(C_H_TOTAL - 1);
    localparam logic [COORD_W-1:0] C_V_LAST    = COORD_W'(C_V_TOTAL - 1);
    localparam logic [1:0]         C_SYNC_IDLE = {2{~SYNC_ACTIVE}};

    generate
        if (C_H_TOTAL > MAX_TOTAL || C_V_TOTAL > MAX_TOTAL) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed coordinate range");
        end
        if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
            $error("vga_timing_gen: PIPE_DELAY must be within 0..7");
        end
    endgenerate

    logic [COORD_W-1:0]     r_x;
    logic [COORD_W-1:0]     r_y;
    logic [COORD_W-1:0]     w_next_x;
    logic [COORD_W-1:0]     w_next_y;
    logic                   w_x_wrap;
    logic                   w_y_wrap;
    logic                   r_blank;
    logic                   r_line_start;
    logic                   r_frame_start;
    logic [FRAME_CNT_W-1:0] r_frame_count;
    logic [1:0]             w_sync_raw;
    logic [1:0]             r_sync_raw;
    logic [1:0]             w_sync_dly;

    // Everything registered below is derived from next-state counts, so each
    // output describes the coordinate pair it is presented alongside.
    always_comb begin
        w_x_wrap = (r_x == C_H_LAST);
        w_y_wrap = (r_y == C_V_LAST);
        w_next_x = w_x_wrap ? '0 : r_x + COORD_W'(1);
        w_next_y = r_y;
        if (w_x_wrap) begin
            w_next_y = w_y_wrap ? '0 : r_y + COORD_W'(1);
        end
        w_sync_raw[1] = in_window(int'(w_next_x), H_VISIBLE + H_FRONT, H_SYNC)
                        ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        w_sync_raw[0] = in_window(int'(w_next_y), V_VISIBLE + V_FRONT, V_SYNC)
                        ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_x           <= '0;
            r_y           <= '0;
            r_blank       <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
            r_sync_raw    <= C_SYNC_IDLE;
        end else begin
            r_x           <= w_next_x;
            r_y           <= w_next_y;
            r_blank       <= (int'(w_next_x) < H_VISIBLE) && (int'(w_next_y) < V_VISIBLE);
            r_line_start  <= w_x_wrap;
            r_frame_start <= w_x_wrap && w_y_wrap;
            r_sync_raw    <= w_sync_raw;
            if (w_x_wrap && w_y_wrap) begin
                r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
            end
        end
    end

    // Extra stages align hs/vs with the render stage's registered colour.
    sync_delay_line #(
        .DEPTH     (PIPE_DELAY),
        .WIDTH     (2),
        .RESET_VAL (C_SYNC_IDLE)
    ) u_sync_delay (
        .clk     (vga_clk),
        .reset_n (reset_n),
        .din     (r_sync_raw),
        .dout    (w_sync_dly)
    );

    assign vga.DrawX       = r_x;
    assign vga.DrawY       = r_y;
    assign vga.blank       = r_blank;
    assign vga.hs          = w_sync_dly[1];
    assign vga.vs          = w_sync_dly[0];
    assign vga.line_start  = r_line_start;
    assign vga.frame_start = r_frame_start;
    assign vga.frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Self-checking bench: default, zero-delay and miniature rasters.
//  Revision : 1.0
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    vga_timing_gen_if vif_def ();
    vga_timing_gen_if vif_pd0 ();
    vga_timing_gen_if vif_sml ();

    vga_timing_gen u_def (.vga_clk(clk), .reset_n(reset_n), .vga(vif_def));

    vga_timing_gen #(.PIPE_DELAY(0)) u_pd0 (.vga_clk(clk), .reset_n(reset_n), .vga(vif_pd0));

    // Miniature raster: 15 x 9, active-high sync, 3-cycle sync delay
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .SYNC_ACTIVE(1'b1), .PIPE_DELAY(3)
    ) u_sml (.vga_clk(clk), .reset_n(reset_n), .vga(vif_sml));

    typedef struct {
        int x;
        int y;
        bit blank;
        bit hs;
        bit vs;
        bit ls;
        bit fs;
        int fc;
    } exp_t;

    typedef struct {
        int k;
        int x;
        int y;
        bit blank;
        bit hs;
        bit ls;
        bit pd0_hs;
    } vec_t;

    int nvec = 0;
    int nerr = 0;
    int k    = 0;
    bit mon_en = 1'b0;

    // Cycles elapsed since the last reset edge.
    always @(posedge clk) begin
        if (!reset_n) k <= 0;
        else          k <= k + 1;
    end

    // Reference: everything follows from k by division and remainder.
    function automatic exp_t model(input int kk, input int hv, input int hf, input int hsw,
                                   input int hb, input int vv, input int vf, input int vsw,
                                   input int vb, input int pd, input bit act);
        exp_t e;
        int ht = hv + hf + hsw + hb;
        int vt = vv + vf + vsw + vb;
        int fr = ht * vt;
        int xp;
        int yp;
        e.x     = kk % ht;
        e.y     = (kk / ht) % vt;
        e.blank = (e.x < hv) && (e.y < vv);
        e.ls    = (kk > 0) && (e.x == 0);
        e.fs    = (kk > 0) && (kk % fr == 0);
        e.fc    = (kk / fr) % 65536;
        if (kk < pd) begin
            e.hs = ~act;
            e.vs = ~act;
        end else begin
            xp   = (kk - pd) % ht;
            yp   = ((kk - pd) / ht) % vt;
            e.hs = (xp >= hv + hf && xp < hv + hf + hsw) ? act : ~act;
            e.vs = (yp >= vv + vf && yp < vv + vf + vsw) ? act : ~act;
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at k=%0d: got %0d, want %0d", name, k, act, exp);
        end
    endtask

    task automatic check_dut(input string tag, input exp_t e,
                             input logic [9:0] x, input logic [9:0] y, input logic bl,
                             input logic hs, input logic vs, input logic ls,
                             input logic fs, input logic [15:0] fc);
        chk({tag, ".DrawX"}, int'(x), e.x);
        chk({tag, ".DrawY"}, int'(y), e.y);
        chk({tag, ".blank"}, int'(bl), int'(e.blank));
        chk({tag, ".hs"}, int'(hs), int'(e.hs));
        chk({tag, ".vs"}, int'(vs), int'(e.vs));
        chk({tag, ".line_start"}, int'(ls), int'(e.ls));
        chk({tag, ".frame_start"}, int'(fs), int'(e.fs));
        chk({tag, ".frame_count"}, int'(fc), e.fc);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_dut("def", model(k, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0),
                      vif_def.DrawX, vif_def.DrawY, vif_def.blank, vif_def.hs, vif_def.vs,
                      vif_def.line_start, vif_def.frame_start, vif_def.frame_count);
            check_dut("pd0", model(k, 640, 16, 96, 48, 480, 10, 2, 33, 0, 1'b0),
                      vif_pd0.DrawX, vif_pd0.DrawY, vif_pd0.blank, vif_pd0.hs, vif_pd0.vs,
                      vif_pd0.line_start, vif_pd0.frame_start, vif_pd0.frame_count);
            check_dut("sml", model(k, 8, 2, 3, 2, 4, 1, 2, 2, 3, 1'b1),
                      vif_sml.DrawX, vif_sml.DrawY, vif_sml.blank, vif_sml.hs, vif_sml.vs,
                      vif_sml.line_start, vif_sml.frame_start, vif_sml.frame_count);
        end
    end

    task automatic wait_k(input int target);
        int guard = 0;
        while (k < target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        chk("wait_k_reached", k, target);
    endtask

    task automatic pulse_reset(input int cycles);
        reset_n = 1'b0;
        repeat (cycles) @(negedge clk);
        reset_n = 1'b1;
    endtask

    vec_t tab [15];

    initial begin
        int cnt_hs_def;
        int cnt_hs_pd0;
        int cnt_vs_sml;

        // {k, DrawX, DrawY, blank, hs(PIPE_DELAY=2), line_start, hs(PIPE_DELAY=0)}
        tab[0]  = '{0,    0,   0, 1'b1, 1'b1, 1'b0, 1'b1};
        tab[1]  = '{1,    1,   0, 1'b1, 1'b1, 1'b0, 1'b1};
        tab[2]  = '{639,  639, 0, 1'b1, 1'b1, 1'b0, 1'b1};
        tab[3]  = '{640,  640, 0, 1'b0, 1'b1, 1'b0, 1'b1};
        tab[4]  = '{655,  655, 0, 1'b0, 1'b1, 1'b0, 1'b1};
        tab[5]  = '{656,  656, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[6]  = '{657,  657, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[7]  = '{658,  658, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[8]  = '{751,  751, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[9]  = '{752,  752, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[10] = '{753,  753, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[11] = '{754,  754, 0, 1'b0, 1'b1, 1'b0, 1'b1};
        tab[12] = '{799,  799, 0, 1'b0, 1'b1, 1'b0, 1'b1};
        tab[13] = '{800,  0,   1, 1'b1, 1'b1, 1'b1, 1'b1};
        tab[14] = '{801,  1,   1, 1'b1, 1'b1, 1'b0, 1'b1};

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        mon_en  = 1'b1;
        reset_n = 1'b1;

        // Reset after activity returns every output to its idle value
        repeat (300) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_DrawX", int'(vif_def.DrawX), 0);
        chk("rst_DrawY", int'(vif_def.DrawY), 0);
        chk("rst_blank", int'(vif_def.blank), 1);
        chk("rst_hs", int'(vif_def.hs), 1);
        chk("rst_vs", int'(vif_def.vs), 1);
        chk("rst_frame_count", int'(vif_def.frame_count), 0);
        chk("rst_line_start", int'(vif_def.line_start), 0);
        chk("rst_frame_start", int'(vif_def.frame_start), 0);
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            wait_k(tab[i].k);
            chk("tab_DrawX", int'(vif_def.DrawX), tab[i].x);
            chk("tab_DrawY", int'(vif_def.DrawY), tab[i].y);
            chk("tab_blank", int'(vif_def.blank), int'(tab[i].blank));
            chk("tab_hs", int'(vif_def.hs), int'(tab[i].hs));
            chk("tab_line_start", int'(vif_def.line_start), int'(tab[i].ls));
            chk("tab_pd0_hs", int'(vif_pd0.hs), int'(tab[i].pd0_hs));
        end

        // Sync pulse widths over one full line / one full miniature frame
        wait_k(1600);
        cnt_hs_def = 0;
        cnt_hs_pd0 = 0;
        cnt_vs_sml = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (vif_def.hs == 1'b0) cnt_hs_def++;
            if (vif_pd0.hs == 1'b0) cnt_hs_pd0++;
            if (i < 135 && vif_sml.vs == 1'b1) cnt_vs_sml++;
        end
        chk("hs_low_cycles_def", cnt_hs_def, 96);
        chk("hs_low_cycles_pd0", cnt_hs_pd0, 96);
        chk("vs_active_cycles_sml", cnt_vs_sml, 30);

        // Reset while hs is asserted must flush the delay line
        wait_k(3100);
        chk("pre_rst_hs_def", int'(vif_def.hs), 0);
        pulse_reset(1);
        chk("flush_hs_def", int'(vif_def.hs), 1);
        chk("flush_hs_pd0", int'(vif_pd0.hs), 1);

        // Reset in the middle of the miniature vsync
        wait_k(79);
        chk("pre_rst_vs_sml", int'(vif_sml.vs), 1);
        pulse_reset(1);
        chk("flush_vs_sml", int'(vif_sml.vs), 0);
        @(negedge clk);
        chk("flush_vs_sml_k1", int'(vif_sml.vs), 0);

        // Reset on the last pixel of the frame: no strobe, no count
        wait_k(134);
        chk("last_px_x", int'(vif_sml.DrawX), 14);
        chk("last_px_y", int'(vif_sml.DrawY), 8);
        pulse_reset(1);
        chk("wrap_rst_x", int'(vif_sml.DrawX), 0);
        chk("wrap_rst_y", int'(vif_sml.DrawY), 0);
        chk("wrap_rst_fs", int'(vif_sml.frame_start), 0);
        chk("wrap_rst_fc", int'(vif_sml.frame_count), 0);

        // Natural wraps: strobes and counter on the same edge
        wait_k(135);
        chk("wrap1_fs", int'(vif_sml.frame_start), 1);
        chk("wrap1_ls", int'(vif_sml.line_start), 1);
        chk("wrap1_fc", int'(vif_sml.frame_count), 1);
        wait_k(136);
        chk("wrap1_fs_drop", int'(vif_sml.frame_start), 0);
        wait_k(270);
        chk("wrap2_fc", int'(vif_sml.frame_count), 2);

        // Randomised run lengths and reset pulses, checked by the monitor
        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(1, 700)) @(negedge clk);
            pulse_reset($urandom_range(1, 3));
        end
        repeat (500) @(negedge clk);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
